// File: rtl/ads8688_scan_scheduler.sv
// ADS8688 command sequencer: device reset, per-channel range programming, then paced
// round-robin MAN_Ch_n scanning with channel-tagged samples realigned to the ADC's result pipeline.
module ads8688_scan_scheduler #(
  parameter logic [15:0] RST_CMD   = 16'h8500,
  parameter logic [15:0] RST_WAIT  = 16'd1000,
  parameter logic [7:0]  DEF_RANGE = 8'h01
) (
  input  logic        CLK_50M,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [7:0]  ch_mask,
  input  logic [7:0]  range_sel,
  input  logic [15:0] pace_div,
  output logic        frm_start,
  output logic [15:0] frm_cmd,
  input  logic        frm_done,
  input  logic [15:0] frm_rdata,
  output logic        smp_valid,
  output logic [2:0]  smp_ch,
  output logic [15:0] smp_data,
  output logic        cfg_done,
  output logic        busy
);

  typedef enum logic [2:0] {StIdle, StRstTx, StRstHold, StCfgTx, StScanTx, StDrain} state_e;

  state_e      state_q, state_d;
  logic        enable_q;
  logic [7:0]  mask_q, mask_d, range_q, range_d;
  logic [2:0]  ptr_q, ptr_d, cur_ch_q, cur_ch_d, tag_ch_q, tag_ch_d;
  logic        tag_vld_q, tag_vld_d, cfg_last_q, cfg_last_d, out_q, out_d;
  logic [15:0] pace_q, pace_d, hold_q, hold_d;
  logic        frm_start_q, frm_start_d;
  logic [15:0] frm_cmd_q, frm_cmd_d;
  logic        smp_valid_q, smp_valid_d;
  logic [2:0]  smp_ch_q, smp_ch_d;
  logic [15:0] smp_data_q, smp_data_d;
  logic        cfg_done_q, cfg_done_d;

  logic        en_rise, done_ok, free, pace_ok, issue_cfg, issue_scan;
  logic [2:0]  first_ch, nxt_ptr, cfg_ch, cfg_nxt;

  // Next set bit strictly after p, wrapping; returns p when it is the only set bit.
  function automatic logic [2:0] next_set(input logic [7:0] m, input logic [2:0] p);
    logic [2:0] r, k;
    r = p;
    for (int i = 7; i >= 1; i--) begin
      k = p + 3'(i);
      if (m[k]) r = k;
    end
    return r;
  endfunction

  function automatic logic [15:0] cfg_word(input logic [2:0] n, input logic [7:0] rng);
    return {7'(n) + 7'd5, 1'b1, rng};
  endfunction

  function automatic logic [15:0] scan_word(input logic [2:0] n);
    return 16'hC000 | (16'(n) << 10);
  endfunction

  assign en_rise  = enable & ~enable_q;
  assign done_ok  = frm_done & out_q;  // stray done pulses are ignored
  assign free     = ~out_q | done_ok;
  assign pace_ok  = pace_q <= 16'd1;
  assign first_ch = next_set(mask_q, 3'd7);
  assign nxt_ptr  = next_set(mask_q, ptr_q);
  assign cfg_nxt  = next_set(mask_q, cfg_ch);

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    range_d     = range_q;
    ptr_d       = ptr_q;
    cur_ch_d    = cur_ch_q;
    tag_ch_d    = tag_ch_q;
    tag_vld_d   = tag_vld_q;
    cfg_last_d  = cfg_last_q;
    out_d       = out_q & ~done_ok;
    pace_d      = (pace_q != 16'd0) ? pace_q - 16'd1 : 16'd0;
    hold_d      = hold_q;
    frm_start_d = 1'b0;
    frm_cmd_d   = frm_cmd_q;
    smp_valid_d = 1'b0;
    smp_ch_d    = smp_ch_q;
    smp_data_d  = smp_data_q;
    cfg_done_d  = cfg_done_q;
    issue_cfg   = 1'b0;
    issue_scan  = 1'b0;
    cfg_ch      = ptr_q;

    if (state_q != StIdle && state_q != StDrain && !enable) begin
      state_d    = (out_q && !done_ok) ? StDrain : StIdle;
      tag_vld_d  = 1'b0;
      cfg_done_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (en_rise && ch_mask != 8'd0) begin
            mask_d      = ch_mask;
            range_d     = (range_sel == 8'd0) ? DEF_RANGE : range_sel;
            frm_start_d = 1'b1;
            frm_cmd_d   = RST_CMD;
            state_d     = StRstTx;
          end
        end
        StRstTx: begin
          if (done_ok) begin
            state_d = StRstHold;
            hold_d  = RST_WAIT;
          end
        end
        StRstHold: begin
          if (hold_q <= 16'd1) begin
            issue_cfg = 1'b1;
            cfg_ch    = first_ch;
            state_d   = StCfgTx;
          end else begin
            hold_d = hold_q - 16'd1;
          end
        end
        StCfgTx: begin
          if (done_ok) begin
            if (cfg_last_q) begin
              state_d    = StScanTx;
              cfg_done_d = 1'b1;
              issue_scan = pace_ok;
            end else begin
              issue_cfg = 1'b1;
            end
          end
        end
        StScanTx: begin
          // Data returned now belongs to the channel commanded one frame earlier.
          if (done_ok) begin
            if (tag_vld_q) begin
              smp_valid_d = 1'b1;
              smp_ch_d    = tag_ch_q;
              smp_data_d  = frm_rdata;
            end
            tag_ch_d  = cur_ch_q;
            tag_vld_d = 1'b1;
          end
          if (free && pace_ok) issue_scan = 1'b1;
        end
        StDrain: begin
          if (done_ok || !out_q) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end

    if (issue_cfg) begin
      frm_start_d = 1'b1;
      frm_cmd_d   = cfg_word(cfg_ch, range_q);
      cur_ch_d    = cfg_ch;
      ptr_d       = cfg_nxt;
      cfg_last_d  = cfg_nxt <= cfg_ch;
    end
    if (issue_scan) begin
      frm_start_d = 1'b1;
      frm_cmd_d   = scan_word(ptr_q);
      cur_ch_d    = ptr_q;
      ptr_d       = nxt_ptr;
    end
    if (frm_start_d) begin
      out_d  = 1'b1;
      pace_d = (pace_div == 16'd0) ? 16'd1 : pace_div;
    end
  end

  always_ff @(posedge CLK_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      enable_q    <= 1'b0;
      mask_q      <= 8'd0;
      range_q     <= 8'd0;
      ptr_q       <= 3'd0;
      cur_ch_q    <= 3'd0;
      tag_ch_q    <= 3'd0;
      tag_vld_q   <= 1'b0;
      cfg_last_q  <= 1'b0;
      out_q       <= 1'b0;
      pace_q      <= 16'd0;
      hold_q      <= 16'd0;
      frm_start_q <= 1'b0;
      frm_cmd_q   <= 16'h0000;
      smp_valid_q <= 1'b0;
      smp_ch_q    <= 3'd0;
      smp_data_q  <= 16'd0;
      cfg_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      enable_q    <= enable;
      mask_q      <= mask_d;
      range_q     <= range_d;
      ptr_q       <= ptr_d;
      cur_ch_q    <= cur_ch_d;
      tag_ch_q    <= tag_ch_d;
      tag_vld_q   <= tag_vld_d;
      cfg_last_q  <= cfg_last_d;
      out_q       <= out_d;
      pace_q      <= pace_d;
      hold_q      <= hold_d;
      frm_start_q <= frm_start_d;
      frm_cmd_q   <= frm_cmd_d;
      smp_valid_q <= smp_valid_d;
      smp_ch_q    <= smp_ch_d;
      smp_data_q  <= smp_data_d;
      cfg_done_q  <= cfg_done_d;
    end
  end

  assign frm_start = frm_start_q;
  assign frm_cmd   = frm_cmd_q;
  assign smp_valid = smp_valid_q;
  assign smp_ch    = smp_ch_q;
  assign smp_data  = smp_data_q;
  assign cfg_done  = cfg_done_q;
  assign busy      = state_q != StIdle;

endmodule

// File: tb/tb_ads8688_scan_scheduler.sv
// Bench for ads8688_scan_scheduler: a fixed-latency frame engine plus a frame-timeline model
// predicting every command, start cycle, cfg_done rise and tagged sample.
module tb_ads8688_scan_scheduler;
  localparam int RstWait = 1000;

  logic        CLK_50M = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  ch_mask = 8'd0;
  logic [7:0]  range_sel = 8'd0;
  logic [15:0] pace_div = 16'd0;
  logic        frm_start;
  logic [15:0] frm_cmd;
  logic        frm_done;
  logic [15:0] frm_rdata = 16'd0;
  logic        smp_valid;
  logic [2:0]  smp_ch;
  logic [15:0] smp_data;
  logic        cfg_done;
  logic        busy;
  logic        eng_done = 1'b0;
  logic        spur_done = 1'b0;

  assign frm_done = eng_done | spur_done;

  ads8688_scan_scheduler dut (
    .CLK_50M  (CLK_50M),
    .rst_n    (rst_n),
    .enable   (enable),
    .ch_mask  (ch_mask),
    .range_sel(range_sel),
    .pace_div (pace_div),
    .frm_start(frm_start),
    .frm_cmd  (frm_cmd),
    .frm_done (frm_done),
    .frm_rdata(frm_rdata),
    .smp_valid(smp_valid),
    .smp_ch   (smp_ch),
    .smp_data (smp_data),
    .cfg_done (cfg_done),
    .busy     (busy)
  );

  always #10 CLK_50M = ~CLK_50M;

  int cyc = 0;
  always @(posedge CLK_50M) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Frame engine: done 'lat' cycles after start; scan data either indexed or random.
  int          lat = 20;
  int          eng_cnt = 0;
  bit          idx_mode = 1'b1;
  int          scan_idx = 0;
  int          log_done_cyc[$];
  logic [15:0] log_done_cmd[$];
  logic [15:0] log_done_data[$];

  initial forever begin
    @(negedge CLK_50M);
    eng_done = 1'b0;
    if (!rst_n) begin
      eng_cnt = 0;
    end else begin
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          eng_done = 1'b1;
          if (frm_cmd[15:14] == 2'b11) begin
            frm_rdata = idx_mode ? 16'h1000 + 16'(scan_idx) : 16'($urandom);
            scan_idx++;
          end else begin
            frm_rdata = 16'($urandom);
          end
          log_done_cyc.push_back(cyc);
          log_done_cmd.push_back(frm_cmd);
          log_done_data.push_back(frm_rdata);
        end
      end
      if (frm_start) eng_cnt = lat;
    end
  end

  int          log_st_cyc[$];
  logic [15:0] log_st_cmd[$];
  int          log_smp_cyc[$];
  logic [2:0]  log_smp_ch[$];
  logic [15:0] log_smp_data[$];
  int          cfg_rise_cyc = -1;
  logic        cfg_prev = 1'b0;

  always @(negedge CLK_50M) begin
    if (frm_start) begin
      log_st_cyc.push_back(cyc);
      log_st_cmd.push_back(frm_cmd);
    end
    if (smp_valid) begin
      log_smp_cyc.push_back(cyc);
      log_smp_ch.push_back(smp_ch);
      log_smp_data.push_back(smp_data);
    end
    if (cfg_done && !cfg_prev && cfg_rise_cyc < 0) cfg_rise_cyc = cyc;
    cfg_prev = cfg_done;
  end

  task automatic clear_logs();
    log_st_cyc.delete(); log_st_cmd.delete();
    log_done_cyc.delete(); log_done_cmd.delete(); log_done_data.delete();
    log_smp_cyc.delete(); log_smp_ch.delete(); log_smp_data.delete();
    cfg_rise_cyc = -1;
    scan_idx = 0;
  endtask

  // Enables a run and checks the first nfr frames against the frame timeline model.
  task automatic run_scn(input logic [7:0] mask, input logic [7:0] rsel, input logic [15:0] pd,
                         input int l, input int nfr, input bit imode);
    int          e, nc, p_eff, budget, nscan, exp_ns, k, a, b;
    int          ch_list[$];
    int          exp_t[$];
    logic [15:0] exp_c[$];
    logic [7:0]  rng;
    logic [6:0]  addr;
    @(negedge CLK_50M);
    ch_mask = mask; range_sel = rsel; pace_div = pd; lat = l; idx_mode = imode;
    clear_logs();
    e = cyc;
    enable = 1'b1;

    for (int n = 0; n < 8; n++) if (mask[n]) ch_list.push_back(n);
    nc    = ch_list.size();
    rng   = (rsel == 8'd0) ? 8'h01 : rsel;
    p_eff = (pd == 16'd0) ? 1 : int'(pd);
    for (int f = 0; f < nfr; f++) begin
      if (f == 0) begin
        exp_c.push_back(16'h8500);
        exp_t.push_back(e + 1);
      end else if (f <= nc) begin
        addr = 7'(5 + ch_list[f - 1]);
        exp_c.push_back({addr, 1'b1, rng});
        exp_t.push_back(exp_t[f - 1] + l + 1 + ((f == 1) ? RstWait : 0));
      end else begin
        exp_c.push_back(16'hC000 | 16'(ch_list[(f - 1 - nc) % nc] << 10));
        a = exp_t[f - 1] + l + 1;
        b = exp_t[f - 1] + p_eff;
        exp_t.push_back((a > b) ? a : b);
      end
    end

    budget = exp_t[nfr - 1] + l + 20;
    while (log_done_cyc.size() < nfr && cyc < budget) @(negedge CLK_50M);
    chk("run_timeout", 32'(log_done_cyc.size() < nfr), 32'd0);
    repeat (2) @(negedge CLK_50M);

    for (int f = 0; f < nfr && f < log_done_cyc.size(); f++) begin
      chk($sformatf("start_cmd[%0d]", f), log_st_cmd[f], exp_c[f]);
      chk($sformatf("start_cyc[%0d]", f), log_st_cyc[f], exp_t[f]);
      chk($sformatf("done_cmd[%0d]", f), log_done_cmd[f], exp_c[f]);
    end
    chk("cfg_rise", cfg_rise_cyc, (nfr > nc) ? exp_t[nc] + l + 1 : -1);
    chk("busy_run", busy, 1'b1);

    nscan  = nfr - 1 - nc;
    exp_ns = (nscan >= 2) ? nscan - 1 : 0;
    chk("smp_count", log_smp_cyc.size(), exp_ns);
    for (int j = 1; j < nscan && j <= log_smp_cyc.size(); j++) begin
      k = 1 + nc + j;
      chk($sformatf("smp_cyc[%0d]", j), log_smp_cyc[j - 1], exp_t[k] + l + 1);
      chk($sformatf("smp_ch[%0d]", j), log_smp_ch[j - 1], ch_list[(j - 1) % nc]);
      chk($sformatf("smp_data[%0d]", j), log_smp_data[j - 1], log_done_data[k]);
    end
  endtask

  task automatic stop_run();
    int t0;
    @(negedge CLK_50M);
    enable = 1'b0;
    t0 = cyc;
    while (busy && cyc < t0 + lat + 10) @(negedge CLK_50M);
    chk("stop_busy", busy, 1'b0);
    chk("stop_cfg_done", cfg_done, 1'b0);
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, n_sm, n_st, t0;
    bit bad;

    repeat (3) @(negedge CLK_50M);
    chk("rst_frm_start", frm_start, 1'b0);
    chk("rst_frm_cmd", frm_cmd, 16'h0000);
    chk("rst_smp_valid", smp_valid, 1'b0);
    chk("rst_smp_ch", smp_ch, 3'd0);
    chk("rst_smp_data", smp_data, 16'd0);
    chk("rst_cfg_done", cfg_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge CLK_50M);

    // Three channels, indexed scan data, unpaced.
    run_scn(8'h07, 8'h01, 16'd0, 20, 13, 1'b1);
    stop_run();
    // Channels 0 and 7, default range, pace-bound scanning.
    run_scn(8'h81, 8'h00, 16'd500, 40, 9, 1'b0);
    stop_run();
    // Pace 0 and done-bound pace 3.
    run_scn(8'($urandom_range(1, 255)), 8'($urandom), 16'd0, 5, 14, 1'b0);
    stop_run();
    run_scn(8'($urandom_range(1, 255)), 8'($urandom), 16'd3, 10, 14, 1'b0);
    stop_run();
    for (int r = 0; r < 3; r++) begin
      run_scn(8'($urandom_range(1, 255)), 8'($urandom), 16'($urandom_range(0, 40)),
              $urandom_range(1, 30), 15, 1'b0);
      stop_run();
    end

    // Enable drop 8 cycles into a scan frame: drain, then idle.
    run_scn(8'h07, 8'h01, 16'd0, 20, 6, 1'b1);
    chk("drain_next_start", 32'(log_st_cyc.size() >= 7), 32'd1);
    if (log_st_cyc.size() >= 7) begin
      s = log_st_cyc[6];
      while (cyc < s + 8) @(negedge CLK_50M);
      n_sm = log_smp_cyc.size();
      n_st = log_st_cyc.size();
      enable = 1'b0;
      bad = 1'b0;
      while (cyc < s + 20) begin
        @(negedge CLK_50M);
        if (!busy) bad = 1'b1;
      end
      chk("drain_busy_held", bad, 1'b0);
      @(negedge CLK_50M);
      chk("drain_busy_low", busy, 1'b0);
      chk("drain_cfg_done", cfg_done, 1'b0);
      repeat (10) @(negedge CLK_50M);
      chk("drain_no_start", log_st_cyc.size(), n_st);
      chk("drain_no_smp", log_smp_cyc.size(), n_sm);
    end
    run_scn(8'h07, 8'h01, 16'd0, 20, 7, 1'b1);
    stop_run();

    // Asynchronous reset in the middle of configuration.
    @(negedge CLK_50M);
    clear_logs();
    ch_mask = 8'h07; range_sel = 8'h01; pace_div = 16'd0; lat = 20;
    enable = 1'b1;
    t0 = cyc;
    while (log_st_cyc.size() < 3 && cyc < t0 + 1200) @(negedge CLK_50M);
    chk("cfg_reach", 32'(log_st_cyc.size() >= 3), 32'd1);
    repeat (5) @(negedge CLK_50M);
    rst_n = 1'b0;
    #1;
    chk("arst_frm_start", frm_start, 1'b0);
    chk("arst_frm_cmd", frm_cmd, 16'h0000);
    chk("arst_smp_valid", smp_valid, 1'b0);
    chk("arst_smp_ch", smp_ch, 3'd0);
    chk("arst_smp_data", smp_data, 16'd0);
    chk("arst_cfg_done", cfg_done, 1'b0);
    chk("arst_busy", busy, 1'b0);
    enable = 1'b0;
    repeat (3) @(negedge CLK_50M);
    rst_n = 1'b1;
    n_st = log_st_cyc.size();
    repeat (20) @(negedge CLK_50M);
    chk("post_rst_no_start", log_st_cyc.size(), n_st);
    chk("post_rst_busy", busy, 1'b0);

    // Zero mask at the enable edge, then a stray done and a mask change without an edge.
    ch_mask = 8'h00;
    enable = 1'b1;
    repeat (30) @(negedge CLK_50M);
    chk("zero_mask_busy", busy, 1'b0);
    chk("zero_mask_no_start", log_st_cyc.size(), n_st);
    spur_done = 1'b1;
    @(negedge CLK_50M);
    spur_done = 1'b0;
    ch_mask = 8'h07;
    repeat (10) @(negedge CLK_50M);
    chk("stray_done_no_smp", log_smp_cyc.size(), 0);
    chk("no_edge_no_start", log_st_cyc.size(), n_st);
    chk("no_edge_busy", busy, 1'b0);
    enable = 1'b0;
    repeat (2) @(negedge CLK_50M);
    run_scn(8'h07, 8'h01, 16'd0, 20, 8, 1'b1);
    stop_run();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
